// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// digits_needed() gives the smallest digit count whose decimal range exceeds 2**bin_w.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam logic [3:0] BCD_ADJ_TH  = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

  function automatic int digits_needed(input int bin_w);
    longint unsigned lim;
    longint unsigned p;
    int              d;
    lim = 64'd1 << bin_w;
    p   = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p <= lim) begin
        p = p * 10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One BCD digit pre-shift correction: values 5..9 get +3 so the next left shift carries.
// Purely combinational; wraps within 4 bits by design.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= BCD_ADJ_TH) ? d_i + BCD_ADJ_ADD : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: accept -> BIN_W shift cycles -> result held in DONE.
// Result valid BIN_W cycles after accept; holds BCD/out_valid stable until out_ready.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   BCD
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if (BIN_W < 1) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be at least 1");
  end
  if (DIGITS < digits_needed(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small to represent 2**BIN_W");
  end

  bcd_state_t             state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d, acc_adj;
  logic [ACC_W-1:0]       bcd_q, bcd_d;
  logic [BIN_W-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACC_W+BIN_W-1:0] shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i(acc_q[4*g +: 4]),
      .d_o(acc_adj[4*g +: 4])
    );
  end

  // Adjust first, then shift the next binary MSB into the accumulator LSB.
  assign shifted = {acc_adj, shreg_q} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = '0;
          shreg_d = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, shreg_d} = shifted;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          bcd_d   = shifted[ACC_W+BIN_W-1 -: ACC_W];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign BCD = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed and random conversions checked against a decimal-digit model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  bin;
  logic [11:0] BCD;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [3:0]  p_bin;
  logic [7:0]  p_bcd;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .BCD(BCD)
  );

  bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .bin(p_bin),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .BCD(p_bcd)
  );

  function automatic logic [31:0] ref_bcd(input int v, input int digits);
    logic [31:0] r;
    int          rem;
    r   = '0;
    rem = v;
    for (int d = 0; d < digits; d++) begin
      r   = r | (32'(rem % 10) << (4 * d));
      rem = rem / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the 8-bit DUT idle; returns at the negedge where out_valid rose.
  task automatic convert8(input int v, input string tag);
    int lat;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    bin      = 8'(v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    bin      = 8'($urandom);
    check({tag, "_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_bcd"}, BCD, ref_bcd(v, 3));
  endtask

  int          vals [6] = '{0, 9, 10, 99, 100, 255};
  logic [11:0] exps [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};

  initial begin
    int n, lat, acc_cyc, prev_cyc, v, stall, seen;
    rst = 1'b1; in_valid = 1'b0; bin = '0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_bin = '0; p_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", BCD, 0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_bcd", BCD, 0);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      convert8(vals[i], "dir");
      check("dir_table", BCD, 32'(exps[i]));
      @(negedge clk);
      check("dir_xfer_valid", out_valid, 0);
      check("dir_bcd_kept", BCD, 32'(exps[i]));
    end

    // Exhaustive sweep with in_valid held high throughout.
    in_valid = 1'b1;
    bin      = 8'd0;
    prev_cyc = 0;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (!in_ready && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("exh_ready_timeout", 32'(n < 30), 1);
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      if (i > 0) check("exh_interval", acc_cyc - prev_cyc, 10);
      prev_cyc = acc_cyc;
      bin = 8'(i + 1);
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("exh_bcd", BCD, ref_bcd(i, 3));
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure, then a pending word accepted right after the transfer.
    out_ready = 1'b0;
    convert8(173, "bp");
    in_valid = 1'b1;
    bin      = 8'd55;
    repeat (20) begin
      @(negedge clk);
      check("bp_valid_hold", out_valid, 1);
      check("bp_bcd_hold", BCD, 32'h173);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_xfer_valid", out_valid, 0);
    check("bp_xfer_ready", in_ready, 1);
    check("bp_bcd_kept", BCD, 32'h173);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_next_latency", lat, 8);
    check("bp_next_bcd", BCD, 32'h055);
    @(negedge clk);
    check("bp_next_xfer", out_valid, 0);

    // Reset in the middle of a conversion.
    in_valid = 1'b1;
    bin      = 8'd200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_bcd", BCD, 0);
    check("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", seen, 0);
    convert8(42, "post_rst");
    @(negedge clk);
    check("post_rst_xfer", out_valid, 0);

    // Random operands with random sink stalls.
    for (int i = 0; i < 30; i++) begin
      v         = int'($urandom_range(0, 255));
      stall     = int'($urandom_range(0, 3));
      out_ready = (stall == 0);
      convert8(v, "rnd");
      repeat (stall) begin
        @(negedge clk);
        check("rnd_stall_valid", out_valid, 1);
        check("rnd_stall_bcd", BCD, ref_bcd(v, 3));
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("rnd_xfer", out_valid, 0);
    end

    // 4-bit / 2-digit instance.
    p_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("p_in_ready", p_in_ready, 1);
      p_in_valid = 1'b1;
      p_bin      = 4'(i);
      @(posedge clk);
      @(negedge clk);
      p_in_valid = 1'b0;
      p_bin      = 4'($urandom);
      lat = 0;
      while (!p_out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("p_latency", lat, 4);
      check("p_bcd", p_bcd, ref_bcd(i, 2));
      @(negedge clk);
      check("p_xfer", p_out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
